// File: rtl/ofdm_rx_pkg.sv
// rtl/ofdm_rx_pkg.sv - shared types and default sizing for the OFDM receive path
package ofdm_rx_pkg;

    // Defaults track the TX IFFT modulator configuration.
    localparam int NFFT_DEF   = 2048;
    localparam int CP_LEN_DEF = 512;
    localparam int DW_DEF     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ofdm_sym_counter.sv
// rtl/ofdm_sym_counter.sv - per-symbol sample counter with CP / symbol-end flags
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           realign: force the sample count back to 0
//   adv_i           one sample accepted this cycle
//   cp_last_o       current sample is the last cyclic-prefix sample
//   sym_last_o      current sample is the last sample of the symbol
//   fs_i, body_i,   (OFDM_CP_REMOVE_SYMCNT_EN only) frame start, accept is
//   sym_cnt_o       in BODY, and the completed-symbol count
module ofdm_sym_counter
    import ofdm_rx_pkg::*;
#(
    parameter int NFFT   = NFFT_DEF,
    parameter int CP_LEN = CP_LEN_DEF,
    localparam int SYM_LEN = CP_LEN + NFFT,
    localparam int CW      = cnt_w(SYM_LEN)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        adv_i,
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    input  logic        fs_i,
    input  logic        body_i,
    output logic [15:0] sym_cnt_o,
`endif
    output logic        cp_last_o,
    output logic        sym_last_o
);

    logic [CW-1:0] s_cnt_q, s_cnt_d;

    assign sym_last_o = (s_cnt_q == CW'(SYM_LEN - 1));

    // With no prefix the CP state is never entered, so the flag is tied off.
    generate
        if (CP_LEN > 0) begin : g_cp
            assign cp_last_o = (s_cnt_q == CW'(CP_LEN - 1));
        end else begin : g_no_cp
            assign cp_last_o = 1'b0;
        end
    endgenerate

    always_comb begin
        s_cnt_d = s_cnt_q;
        if (clr_i) begin
            s_cnt_d = '0;
        end else if (adv_i) begin
            s_cnt_d = sym_last_o ? '0 : s_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_cnt_q <= '0;
        end else begin
            s_cnt_q <= s_cnt_d;
        end
    end

`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    logic [15:0] sym_cnt_q, sym_cnt_d;

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (fs_i) begin
            sym_cnt_d = '0;
        end else if (adv_i && body_i && sym_last_o) begin
            sym_cnt_d = sym_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sym_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign sym_cnt_o = sym_cnt_q;
`endif

endmodule

// File: rtl/ofdm_cp_remove.sv
// rtl/ofdm_cp_remove.sv - strips the cyclic prefix from each received OFDM symbol
//
// Optional feature macro: OFDM_CP_REMOVE_SYMCNT_EN (adds SYM_CNT_O, SYM_LAST_O).
//
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   DAT_I, CYC_I, STB_I,  sample sink; CYC_I rising marks symbol 0 sample 0,
//   WE_I, ACK_O           a sample moves when CYC_I & STB_I & WE_I & ACK_O
//   DAT_O, CYC_O, STB_O,  useful-sample source, registered, 1-cycle latency;
//   WE_O, ACK_I           a beat moves when STB_O & ACK_I
//   SYM_CNT_O             completed symbols since frame start (optional)
//   SYM_LAST_O            beat carries the last useful sample (optional)
module ofdm_cp_remove
    import ofdm_rx_pkg::*;
#(
    parameter int NFFT   = NFFT_DEF,
    parameter int CP_LEN = CP_LEN_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    ,
    output logic [15:0]   SYM_CNT_O,
    output logic          SYM_LAST_O
`endif
);

    // With no prefix every symbol boundary goes straight back into BODY.
    localparam state_e ST_SYM_START = (CP_LEN == 0) ? ST_BODY : ST_CP;

    state_e        state_q;
    logic          icyc_q;
    logic          stb_q;
    logic          cyc_q;
    logic [DW-1:0] dat_q;

    logic ena;
    logic fs;
    logic out_halt;
    logic body_acc;
    logic cp_last;
    logic sym_last;

    assign ena      = CYC_I & STB_I & WE_I;
    assign fs       = CYC_I & ~icyc_q;
    assign out_halt = stb_q & ~ACK_I;
    // A stalled output blocks intake in CP as well, keeping the sink and
    // source in lock-step.
    assign ACK_O    = ena & ~out_halt & (state_q != ST_IDLE);
    assign body_acc = (state_q == ST_BODY) & ACK_O;

    ofdm_sym_counter #(
        .NFFT   (NFFT),
        .CP_LEN (CP_LEN)
    ) u_sym_counter (
        .clk_i      (CLK_I),
        .rst_ni     (RST_I),
        .clr_i      (~CYC_I | fs),
        .adv_i      (ACK_O),
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        .fs_i       (fs),
        .body_i     (state_q == ST_BODY),
        .sym_cnt_o  (SYM_CNT_O),
`endif
        .cp_last_o  (cp_last),
        .sym_last_o (sym_last)
    );

`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    logic last_q;
    assign SYM_LAST_O = last_q;
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            icyc_q  <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            dat_q   <= '0;
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
            last_q  <= 1'b0;
`endif
        end else begin
            icyc_q <= CYC_I;

            if (!CYC_I) begin
                state_q <= ST_IDLE;
            end else if (fs) begin
                state_q <= ST_SYM_START;
            end else if (ACK_O) begin
                case (state_q)
                    ST_CP:   if (cp_last)  state_q <= ST_BODY;
                    ST_BODY: if (sym_last) state_q <= ST_SYM_START;
                    default: state_q <= state_q;
                endcase
            end

            // Output register reloads whenever the current beat is gone,
            // so a consumed beat and a new accept share one edge.
            if (!out_halt) begin
                stb_q <= body_acc;
                if (body_acc) begin
                    dat_q <= DAT_I;
                end
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
                last_q <= body_acc & sym_last;
`endif
            end

            if (body_acc) begin
                cyc_q <= 1'b1;
            end else if (!CYC_I && !stb_q) begin
                cyc_q <= 1'b0;
            end
        end
    end

    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = cyc_q;

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// tb/tb_ofdm_cp_remove.sv - scoreboard bench for ofdm_cp_remove
module tb_ofdm_cp_remove;

    localparam int NFFT = 8;
    localparam int CP   = 2;
    localparam int L    = CP + NFFT;
    localparam int DW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] dat_i;
    logic          cyc_i, stb_i, we_i;
    logic          ack_i = 1'b1;
    logic          ack_o, cyc_o, stb_o, we_o;
    logic [DW-1:0] dat_o;

    logic [DW-1:0] z_dat_i;
    logic          z_cyc_i, z_stb_i, z_we_i;
    logic          z_ack_i = 1'b1;
    logic          z_ack_o, z_cyc_o, z_stb_o, z_we_o;
    logic [DW-1:0] z_dat_o;

`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    logic [15:0] sym_cnt, z_sym_cnt;
    logic        sym_last, z_sym_last;
`endif

    ofdm_cp_remove #(.NFFT(NFFT), .CP_LEN(CP), .DW(DW)) dut (
        .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i),
        .WE_I(we_i), .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o),
        .WE_O(we_o), .ACK_I(ack_i)
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        , .SYM_CNT_O(sym_cnt), .SYM_LAST_O(sym_last)
`endif
    );

    ofdm_cp_remove #(.NFFT(NFFT), .CP_LEN(0), .DW(DW)) dut_z (
        .CLK_I(clk), .RST_I(rst_n), .DAT_I(z_dat_i), .CYC_I(z_cyc_i), .STB_I(z_stb_i),
        .WE_I(z_we_i), .ACK_O(z_ack_o), .DAT_O(z_dat_o), .CYC_O(z_cyc_o), .STB_O(z_stb_o),
        .WE_O(z_we_o), .ACK_I(z_ack_i)
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        , .SYM_CNT_O(z_sym_cnt), .SYM_LAST_O(z_sym_last)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] z_q[$];
    int            beats = 0;
    int            last_beats = 0;
    int            z_beats = 0;
    bit            z_done = 1'b0;
    bit            stall_en = 1'b0;
    int            stall_left = 0;

    task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Reference: of every L accepted samples in a frame, the first CP are dropped.
    function automatic void model_accept(input int p, input logic [DW-1:0] d);
        exp_t e;
        if ((p % L) >= CP) begin
            e.d    = d;
            e.last = ((p % L) == L - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Downstream ready with random stall runs of 1..3 cycles.
    always @(posedge clk) begin
        #1;
        if (!stall_en) begin
            stall_left = 0;
            ack_i = 1'b1;
        end else if (stall_left > 0) begin
            stall_left--;
            ack_i = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
            stall_left = $urandom_range(0, 2);
            ack_i = 1'b0;
        end else begin
            ack_i = 1'b1;
        end
    end

    bit            prev_halt = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (prev_halt)
                chk(stb_o === 1'b1 && dat_o === prev_dat, "hold_dat", dat_o, prev_dat);
            if (stb_o && !ack_i)
                chk(ack_o === 1'b0, "ack_o_halted", {31'd0, ack_o}, 0);
            if (stb_o) begin
                chk(we_o === 1'b1, "we_o", {31'd0, we_o}, 1);
                chk(cyc_o === 1'b1, "cyc_o_active", {31'd0, cyc_o}, 1);
            end
            if (stb_o && ack_i) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", dat_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(dat_o === e.d, "dat_o", dat_o, e.d);
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
                    chk(sym_last === e.last, "sym_last", {31'd0, sym_last}, {31'd0, e.last});
                    if (sym_last) last_beats++;
`endif
                end
            end
            prev_halt = stb_o && !ack_i;
            prev_dat  = dat_o;
        end else begin
            prev_halt = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] ze;
        if (rst_n === 1'b1 && z_stb_o && z_ack_i) begin
            z_beats++;
            if (z_q.size() == 0) begin
                chk(1'b0, "z_unexpected_beat", z_dat_o, 0);
            end else begin
                ze = z_q.pop_front();
                chk(z_dat_o === ze, "z_dat_o", z_dat_o, ze);
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
                chk(z_sym_last === (z_beats % NFFT == 0), "z_sym_last",
                    {31'd0, z_sym_last}, {31'd0, (z_beats % NFFT == 0)});
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after one cycle with CYC_I low.
    task automatic send_frame(input int n, input int gap_pct);
        int  i = 0;
        int  p = 0;
        int  guard = 0;
        bit  acc;
        cyc_i = 1'b1;
        we_i  = 1'b1;
        stb_i = 1'b0;
        while (i < n && guard < 2000) begin
            if (!stb_i && $urandom_range(0, 99) >= gap_pct) begin
                stb_i = 1'b1;
                dat_i = $urandom;
            end
            @(negedge clk);
            acc = stb_i && ack_o;
            if (acc) begin
                model_accept(p, dat_i);
                p++;
                i++;
            end
            @(posedge clk);
            #1;
            if (acc) stb_i = 1'b0;
            guard++;
        end
        if (i < n) chk(1'b0, "send_timeout", i, n);
        stb_i = 1'b0;
        cyc_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk(stb_o === 1'b0, "stb_o_drained", {31'd0, stb_o}, 0);
        chk(cyc_o === 1'b0, "cyc_o_drained", {31'd0, cyc_o}, 0);
    endtask

    // CP_LEN=0 instance: 16 samples, all forwarded in order.
    initial begin
        int k = 0;
        int guard = 0;
        z_cyc_i = 1'b0; z_stb_i = 1'b0; z_we_i = 1'b0; z_dat_i = '0;
        @(posedge rst_n);
        @(posedge clk);
        #1;
        z_cyc_i = 1'b1; z_we_i = 1'b1; z_stb_i = 1'b1; z_dat_i = $urandom;
        while (k < 16 && guard < 200) begin
            @(negedge clk);
            if (z_ack_o) begin
                z_q.push_back(z_dat_i);
                k++;
            end
            @(posedge clk);
            #1;
            z_dat_i = $urandom;
            guard++;
        end
        z_stb_i = 1'b0;
        z_cyc_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(z_beats == 16, "z_beat_count", z_beats, 16);
        chk(z_q.size() == 0, "z_drain", z_q.size(), 0);
        chk(z_cyc_o === 1'b0, "z_cyc_o_drained", {31'd0, z_cyc_o}, 0);
        z_done = 1'b1;
    end

    initial begin
        int b0, l0, g;
        rst_n = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(dat_o === '0, "rst_dat_o", dat_o, 0);
        chk(stb_o === 1'b0, "rst_stb_o", {31'd0, stb_o}, 0);
        chk(cyc_o === 1'b0, "rst_cyc_o", {31'd0, cyc_o}, 0);
        chk(ack_o === 1'b0, "rst_ack_o", {31'd0, ack_o}, 0);
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        chk(sym_cnt === 16'd0, "rst_sym_cnt", {16'd0, sym_cnt}, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single symbol, no stalls.
        b0 = beats;
        send_frame(10, 0);
        drain();
        chk(beats - b0 == 8, "single_beats", beats - b0, 8);

        // Three back-to-back symbols.
        b0 = beats;
        l0 = last_beats;
        send_frame(30, 0);
        drain();
        chk(beats - b0 == 24, "b2b_beats", beats - b0, 24);
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        chk(last_beats - l0 == 3, "b2b_last", last_beats - l0, 3);
        chk(sym_cnt === 16'd3, "b2b_sym_cnt", {16'd0, sym_cnt}, 3);
`endif

        // Backpressure and source gaps.
        stall_en = 1'b1;
        b0 = beats;
        send_frame(30, 30);
        drain();
        chk(beats - b0 == 24, "stall_beats", beats - b0, 24);
        stall_en = 1'b0;

        // Abort after 5 samples, then a full symbol.
        b0 = beats;
        l0 = last_beats;
        send_frame(5, 0);
        send_frame(10, 0);
        drain();
        chk(beats - b0 == 11, "abort_beats", beats - b0, 11);
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
        chk(sym_cnt === 16'd1, "abort_sym_cnt", {16'd0, sym_cnt}, 1);
        chk(last_beats - l0 == 1, "abort_last", last_beats - l0, 1);
`endif

        // Random frames with stalls and gaps.
        stall_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_frame($urandom_range(1, 35), $urandom_range(0, 40));
        end
        drain();
        stall_en = 1'b0;

        // Asynchronous reset while a beat is on the output.
        cyc_i = 1'b1; we_i = 1'b1;
        g = 0;
        begin : rst_stream
            int p = 0;
            bit acc;
            stb_i = 1'b1;
            dat_i = $urandom;
            while (g < 60) begin
                @(negedge clk);
                if (stb_o) break;
                acc = ack_o;
                if (acc) begin
                    model_accept(p, dat_i);
                    p++;
                end
                @(posedge clk);
                #1;
                if (acc) dat_i = $urandom;
                g++;
            end
        end
        chk(stb_o === 1'b1, "rst_precond_stb", {31'd0, stb_o}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk(stb_o === 1'b0, "async_rst_stb_o", {31'd0, stb_o}, 0);
        chk(dat_o === '0, "async_rst_dat_o", dat_o, 0);
        chk(cyc_o === 1'b0, "async_rst_cyc_o", {31'd0, cyc_o}, 0);
        exp_q.delete();
        stb_i = 1'b0;
        cyc_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b0 = beats;
        send_frame(10, 0);
        drain();
        chk(beats - b0 == 8, "post_rst_beats", beats - b0, 8);

        g = 0;
        while (!z_done && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk(z_done, "z_done", {31'd0, z_done}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/ofdm_cp_remove.md
Name: ofdm_cp_remove

Overview:
- Receive-side counterpart of the transmit IFFT modulator, which appends a cyclic prefix to each OFDM symbol.
- Accepts time-domain OFDM symbols of CP_LEN+NFFT samples on the Wishbone-style streaming sink and discards the first CP_LEN samples of every symbol.
- Forwards the remaining NFFT samples on the Wishbone-style streaming source to the RX FFT demodulator.
- Sits between RX symbol timing and the FFT stage.

Parameters:
- NFFT, 2048, FFT size (useful samples per symbol).
- CP_LEN, 512, cyclic-prefix samples per symbol; range 0..NFFT.
- DW, 32, sample width ({I[15:0],Q[15:0]}); passed through unmodified.

Ports:
- CLK_I  in  1  single clock.
- RST_I  in  1  reset, asynchronous, active-low.
- DAT_I  in  DW  input sample.
- CYC_I  in  1  input frame active; rising edge marks symbol 0, sample 0.
- STB_I  in  1  input sample valid.
- WE_I  in  1  write qualifier; input enable ena = CYC_I & STB_I & WE_I.
- ACK_O  out  1  input sample accepted.
- DAT_O  out  DW  output sample, registered.
- CYC_O  out  1  output frame active, registered.
- STB_O  out  1  output sample valid, registered.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream accepts DAT_O.

Behaviour:
- Reset (RST_I=0, async): DAT_O=0, CYC_O=0, STB_O=0, state=IDLE, s_cnt=0, icyc=0.
- out_halt = STB_O & ~ACK_I. ACK_O = ena & ~out_halt in CP and BODY; ACK_O=0 in IDLE.
- icyc is CYC_I delayed one cycle. Frame start fs = CYC_I & ~icyc.
- s_cnt counts accepted samples per symbol, 0..CP_LEN+NFFT-1, advancing on ACK_O. It wraps to 0 after the last sample of the symbol.
- State IDLE -> CP on fs. If CP_LEN==0, IDLE -> BODY on fs instead.
- State CP: accepted samples are discarded. CP -> BODY when the sample with s_cnt==CP_LEN-1 is accepted.
- State BODY: each accepted sample is registered. DAT_O<=DAT_I and STB_O<=1 in the same edge, giving 1-cycle latency.
- BODY -> CP (or BODY -> BODY when CP_LEN==0) when the sample with s_cnt==CP_LEN+NFFT-1 is accepted.
- Any state -> IDLE when CYC_I=0 for one cycle, with s_cnt cleared. A partial symbol already forwarded is not recalled. fs restarts alignment.
- fs while not in IDLE (CYC_I low for exactly one cycle) has the same effect: realign to CP, s_cnt=0.
- STB_O update rule: when ~out_halt, STB_O <= (state==BODY & ACK_O). While out_halt, DAT_O and STB_O hold.
- Back-to-back symbols: no idle cycles are inserted between useful samples, apart from the cycles spent absorbing the CP.
- CYC_O set on the first BODY sample accept. CYC_O cleared when CYC_I=0 and STB_O=0 (all output drained).
- Simultaneous ACK_I and new accept: the output register is replaced in the same edge, with no bubble.

Optional Feature:
- Macro: OFDM_CP_REMOVE_SYMCNT_EN.
- Defined: adds output SYM_CNT_O[15:0].
  - Reset 0; cleared on fs.
  - Increments when the last BODY sample of a symbol is accepted; wraps 65535 -> 0.
  - Adds output SYM_LAST_O (1 bit, registered alongside STB_O), high on the output beat carrying the last useful sample of a symbol.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Shared package ofdm_rx_pkg holds:
  - state enum (IDLE, CP, BODY);
  - default NFFT/CP_LEN constants matching the TX IFFT configuration (2048/512);
  - sample width DW.
- One natural sub-module: ofdm_sym_counter. It contains s_cnt, the wrap compare, and the optional symbol counter, parameterized by CP_LEN and NFFT.
- The FSM and output register stay in the top module.

Test Plan (NFFT=8, CP_LEN=2 unless stated):
- Reset mid-stream: assert RST_I=0 asynchronously while STB_O=1 -> outputs 0 immediately, with no clock edge needed. After release, the next fs restarts at s_cnt=0.
- Single symbol: CYC_I=1, stream samples 0..9 with ACK_I=1 -> samples 2..9 appear on DAT_O, one cycle after accept. CYC_O rises with sample 2 and falls after CYC_I=0 and the final beat.
- Three back-to-back symbols, values 0..29 -> output 2..9, 12..19, 22..29, exactly 24 STB_O beats.
- Backpressure: ACK_I=0 for 3 cycles mid-BODY -> DAT_O/STB_O hold. ACK_O=0 for those cycles; no sample lost or duplicated. Same check with ACK_I low while in CP: ACK_O stays low until STB_O is consumed.
- Abort: drop CYC_I after 5 samples, restart with 10 new samples -> first run outputs 2..4, second run outputs its samples 2..9. With OFDM_CP_REMOVE_SYMCNT_EN, SYM_CNT_O=1 and SYM_LAST_O pulses once.
- CP_LEN=0: 16 samples -> all 16 forwarded in order; SYM_LAST_O on the 8th and 16th beats when enabled.
